// File: rtl/fetch.sv
// Instruction fetch stage: issues bundle reads to instruction memory and presents one
// 64-bit bundle per cycle to decode, honouring interlock (hold) and branch redirect.
module fetch #(
    parameter int unsigned IMEM_LATENCY = 1,
    parameter int unsigned ADDR_W       = 15,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter logic [5:0]  NOP_OP       = 6'h00  // must match Nop opcode of inst_package
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              interlock,
    input  logic              branch_flag,
    input  logic [31:0]       branch_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [63:0]       imem_dout,
    output logic [31:0]       pc,
    output logic [63:0]       inst,
    output logic              fetch_valid
);
    localparam int unsigned DEPTH = IMEM_LATENCY + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned LW    = $clog2(2 * DEPTH + 1);
    localparam logic [63:0] NOP_BUNDLE = {NOP_OP, 26'b0, NOP_OP, 26'b0};

    logic [31:0]             npc;
    logic [IMEM_LATENCY-1:0] fl_vld;
    logic [31:0]             fl_pc  [IMEM_LATENCY];
    logic [31:0]             q_pc   [DEPTH];
    logic [63:0]             q_inst [DEPTH];
    logic [CW-1:0]           q_cnt;

    logic                    consume;
    logic                    ret;
    logic                    issue;
    logic [31:0]             issue_pc;
    logic [LW-1:0]           load;
    logic [31:0]             q_pc_n   [DEPTH];
    logic [63:0]             q_inst_n [DEPTH];
    logic [CW-1:0]           q_cnt_n;

    // Issue decision: in-flight plus queued bundles must never exceed the queue depth
    always_comb begin
        load = '0;
        for (int i = 0; i < int'(IMEM_LATENCY); i++) begin
            load = load + LW'(fl_vld[i]);
        end
        load     = load + LW'(q_cnt);
        consume  = ~interlock & ~branch_flag & (q_cnt != '0);
        ret      = fl_vld[IMEM_LATENCY-1] & ~branch_flag;
        issue    = branch_flag | ((load - LW'(consume)) < LW'(DEPTH));
        issue_pc = branch_flag ? branch_pc : npc;
    end

    assign imem_en   = rstn & issue;
    assign imem_addr = rstn ? issue_pc[ADDR_W-1:0] : '0;

    // Bundle queue next state: head at index 0, pop shifts down, push lands after survivors
    always_comb begin
        q_pc_n   = q_pc;
        q_inst_n = q_inst;
        q_cnt_n  = q_cnt;
        if (branch_flag) begin
            q_cnt_n = '0;
        end else begin
            if (consume) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    q_pc_n[i]   = q_pc[i+1];
                    q_inst_n[i] = q_inst[i+1];
                end
                q_cnt_n = q_cnt - CW'(1);
            end
            if (ret) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CW'(i) == q_cnt_n) begin
                        q_pc_n[i]   = fl_pc[IMEM_LATENCY-1];
                        q_inst_n[i] = imem_dout;
                    end
                end
                q_cnt_n = q_cnt_n + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            npc         <= RESET_PC;
            fl_vld      <= '0;
            q_cnt       <= '0;
            pc          <= '0;
            inst        <= NOP_BUNDLE;
            fetch_valid <= 1'b0;
            for (int i = 0; i < int'(IMEM_LATENCY); i++) begin
                fl_pc[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else begin
            if (issue) begin
                npc <= issue_pc + 32'd1;
            end
            // A redirect kills every older request still in flight
            for (int i = int'(IMEM_LATENCY) - 1; i > 0; i--) begin
                fl_vld[i] <= fl_vld[i-1] & ~branch_flag;
                fl_pc[i]  <= fl_pc[i-1];
            end
            fl_vld[0] <= issue;
            fl_pc[0]  <= issue_pc;
            q_pc      <= q_pc_n;
            q_inst    <= q_inst_n;
            q_cnt     <= q_cnt_n;
            fetch_valid <= (q_cnt_n != '0);
            inst        <= (q_cnt_n != '0) ? q_inst_n[0] : NOP_BUNDLE;
            if (q_cnt_n != '0) begin
                pc <= q_pc_n[0];
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: two instances (read latency 1 and 2) share one directed stimulus and are
// checked every cycle against a cycle-stamped queue model plus hand-computed literals.
`timescale 1ns/1ps
module tb_fetch;
    localparam logic [5:0]  NOP_OP     = 6'h2a;
    localparam logic [63:0] NOP_BUNDLE = {NOP_OP, 26'b0, NOP_OP, 26'b0};
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int unsigned ADDR_W     = 15;

    logic        clk = 1'b0;
    logic        rstn;
    logic        interlock;
    logic        branch_flag;
    logic [31:0] branch_pc;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = -1;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int lat, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s lat=%0d cyc=%0d got=%h expected=%h", nm, lat, cyc, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int unsigned LAT = g + 1;
        logic [ADDR_W-1:0] addr;
        logic              en;
        logic [63:0]       dout;
        logic [31:0]       pc;
        logic [63:0]       inst;
        logic              fv;
        logic [ADDR_W-1:0] a1, a2;
        logic [31:0]       ra;

        fetch #(.IMEM_LATENCY(LAT), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .NOP_OP(NOP_OP)) dut (
            .clk(clk), .rstn(rstn), .interlock(interlock), .branch_flag(branch_flag),
            .branch_pc(branch_pc), .imem_addr(addr), .imem_en(en), .imem_dout(dout),
            .pc(pc), .inst(inst), .fetch_valid(fv)
        );

        // Memory returns {addr, ~addr} LAT cycles after the request
        always @(posedge clk) begin
            a1 <= addr;
            a2 <= a1;
        end
        assign ra   = 32'((LAT == 1) ? a1 : a2);
        assign dout = {ra, ~ra};

        logic [31:0] mq[$];
        logic [31:0] oq_pc[$];
        int          oq_due[$];
        logic [31:0] m_npc  = RESET_PC;
        logic [31:0] m_last = '0;
        logic [31:0] e_pc;
        int          tick = 0;
        logic        cons;
        logic        iss;

        always @(negedge clk) begin
            #3;
            if (!rstn) begin
                check("rst_pc", LAT, 64'(pc), 64'h0);
                check("rst_inst", LAT, inst, NOP_BUNDLE);
                check("rst_valid", LAT, 64'(fv), 64'h0);
                check("rst_en", LAT, 64'(en), 64'h0);
                check("rst_addr", LAT, 64'(addr), 64'h0);
                mq.delete(); oq_pc.delete(); oq_due.delete();
                m_npc  = RESET_PC;
                m_last = '0;
            end else begin
                e_pc = (mq.size() > 0) ? mq[0] : m_last;
                check("pc", LAT, 64'(pc), 64'(e_pc));
                check("inst", LAT, inst, (mq.size() > 0) ? {e_pc, ~e_pc} : NOP_BUNDLE);
                check("valid", LAT, 64'(fv), 64'(mq.size() > 0));
                if (branch_flag) begin
                    check("br_en", LAT, 64'(en), 64'h1);
                    check("br_addr", LAT, 64'(addr), 64'(branch_pc[ADDR_W-1:0]));
                    mq.delete(); oq_pc.delete(); oq_due.delete();
                    oq_pc.push_back(branch_pc);
                    oq_due.push_back(tick + int'(LAT));
                    m_npc = branch_pc + 32'd1;
                end else begin
                    cons = !interlock && (mq.size() > 0);
                    iss  = (oq_pc.size() + mq.size() - int'(cons)) < int'(LAT) + 1;
                    check("en", LAT, 64'(en), 64'(iss));
                    if (iss) check("addr", LAT, 64'(addr), 64'(m_npc[ADDR_W-1:0]));
                    if (cons) void'(mq.pop_front());
                    if (oq_due.size() > 0 && oq_due[0] == tick) begin
                        mq.push_back(oq_pc.pop_front());
                        void'(oq_due.pop_front());
                    end
                    if (iss) begin
                        oq_pc.push_back(m_npc);
                        oq_due.push_back(tick + int'(LAT));
                        m_npc = m_npc + 32'd1;
                    end
                end
                if (mq.size() > 0) m_last = mq[0];
            end
            tick++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; interlock = 1'b0; branch_flag = 1'b0; branch_pc = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c <= 62; c++) begin
            @(negedge clk);
            cyc         = c;
            rstn        = !(c == 52 || c == 53);
            interlock   = (c >= 7 && c <= 9) || (c >= 20 && c <= 21) ||
                          (c >= 24 && c <= 43 && (c % 2) == 0) || (c >= 48 && c <= 51);
            branch_flag = (c == 15) || (c == 20) || (c == 46);
            branch_pc   = (c == 15) ? 32'h40 : (c == 20) ? 32'h80 : (c == 46) ? 32'h20 : 32'h0;
            #3;
            case (c)
                0: begin
                    check("L_first_en", 1, 64'(h[0].en), 64'h1);
                    check("L_first_addr", 1, 64'(h[0].addr), 64'h0);
                    check("L_first_en2", 2, 64'(h[1].en), 64'h1);
                end
                2: begin
                    check("L_first_pc", 1, 64'(h[0].pc), 64'h0);
                    check("L_first_valid", 1, 64'(h[0].fv), 64'h1);
                    check("L_first_inst", 1, h[0].inst, 64'h00000000_ffffffff);
                end
                3: begin
                    check("L_pc1", 1, 64'(h[0].pc), 64'h1);
                    check("L_lat2_pc0", 2, 64'(h[1].pc), 64'h0);
                    check("L_lat2_valid", 2, 64'(h[1].fv), 64'h1);
                end
                5:  check("L_pc3", 1, 64'(h[0].pc), 64'h3);
                7:  check("L_hold_start", 1, 64'(h[0].pc), 64'h5);
                10: check("L_hold_end", 1, 64'(h[0].pc), 64'h5);
                11: check("L_after_hold", 1, 64'(h[0].pc), 64'h6);
                13: check("L_after_hold8", 1, 64'(h[0].pc), 64'h8);
                15: check("L_br_addr", 1, 64'(h[0].addr), 64'h40);
                16: begin
                    check("L_bubble_valid", 1, 64'(h[0].fv), 64'h0);
                    check("L_bubble_inst", 1, h[0].inst, NOP_BUNDLE);
                    check("L_bubble_pc", 1, 64'(h[0].pc), 64'ha);
                end
                17: check("L_target", 1, 64'(h[0].pc), 64'h40);
                18: check("L_target_inst", 1, h[0].inst, 64'h00000041_ffffffbe);
                21: check("L_brlk_bubble", 1, 64'(h[0].fv), 64'h0);
                22: begin
                    check("L_brlk_target", 1, 64'(h[0].pc), 64'h80);
                    check("L_brlk_bubble2", 2, 64'(h[1].fv), 64'h0);
                end
                23: check("L_brlk_target2", 2, 64'(h[1].pc), 64'h80);
                48: check("L_full_pc", 1, 64'(h[0].pc), 64'h20);
                52: begin
                    check("L_async_pc", 1, 64'(h[0].pc), 64'h0);
                    check("L_async_valid", 1, 64'(h[0].fv), 64'h0);
                    check("L_async_en2", 2, 64'(h[1].en), 64'h0);
                end
                54: check("L_restart_en", 1, 64'(h[0].en), 64'h1);
                56: check("L_restart_pc", 1, 64'(h[0].fv), 64'h1);
                57: check("L_restart_pc1", 1, 64'(h[0].pc), 64'h1);
                default: ;
            endcase
        end
        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
